frame_mapper_sched: RTL

Upstream neighbour of the sender-side frame controller. Generates the row/column frame counters and maps client bytes from the client FIFO into payload columns. It drives the frame controller's row count, column count, payload data and payload valid inputs, all cycle-aligned. It handles FIFO read latency, fills underruns with a stuff byte, and starts and stops cleanly on frame boundaries.

---
 rtl/frame_mapper_sched_if.sv | 26 ++
 rtl/frame_mapper_sched.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/frame_mapper_sched_if.sv
// Bus shared by the client FIFO, the frame mapper and the downstream frame controller.
// The mapper uses the master view; the FIFO/controller side uses the slave view.
interface frame_mapper_sched_if;
   logic [7:0]  i_fifo_data;
   logic        i_fifo_empty;
   logic        o_fifo_rd_en;
   logic [1:0]  o_row_cnt;
   logic [10:0] o_col_cnt;
   logic [7:0]  o_pyld_data;
   logic        o_pyld_data_valid;
   logic        o_stuff;
   logic        o_frame_start;
   logic        o_map_active;

   modport master (
      input  i_fifo_data, i_fifo_empty,
      output o_fifo_rd_en, o_row_cnt, o_col_cnt, o_pyld_data, o_pyld_data_valid,
             o_stuff, o_frame_start, o_map_active
   );

   modport slave (
      output i_fifo_data, i_fifo_empty,
      input  o_fifo_rd_en, o_row_cnt, o_col_cnt, o_pyld_data, o_pyld_data_valid,
             o_stuff, o_frame_start, o_map_active
   );
endinterface

// File: rtl/frame_mapper_sched.sv
// Frame row/column scheduler that maps client FIFO bytes into payload columns.
// Lookahead P0 issues FIFO reads, P1 absorbs the 1-cycle read latency, P2 is the registered output.
module frame_mapper_sched #(
   parameter int unsigned NUM_ROWS   = 4,
   parameter int unsigned NUM_COLS   = 1041,
   parameter int unsigned OH_COLS    = 16,
   parameter logic [7:0]  STUFF_BYTE = 8'h00
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_en,
   frame_mapper_sched_if.master bus,
   output logic [15:0]          o_frame_cnt,
   output logic [15:0]          o_underrun_cnt
);
   localparam logic [1:0]  LAST_ROW   = 2'(NUM_ROWS - 1);
   localparam logic [10:0] LAST_COL   = 11'(NUM_COLS - 1);
   localparam logic [10:0] PYLD_FIRST = 11'(OH_COLS);
   localparam logic [10:0] PYLD_LAST  = 11'(NUM_COLS - 2);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_STOP = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [1:0]  r_la_row;
   logic [1:0]  w_la_row_nxt;
   logic [10:0] r_la_col;
   logic [10:0] w_la_col_nxt;
   logic        w_p0_active;
   logic        w_p0_pyld;
   logic        w_p0_end;
   logic        w_rd_en;

   logic        r_p1_active;
   logic [1:0]  r_p1_row;
   logic [10:0] r_p1_col;
   logic        r_p1_pyld;
   logic        r_p1_rd;
   logic        r_p1_stuff;
   logic        w_p1_end;

   function automatic logic is_pyld_col(input logic [10:0] col);
      return (col >= PYLD_FIRST) && (col <= PYLD_LAST);
   endfunction

   assign w_p0_active      = (r_state != ST_IDLE);
   assign w_p0_pyld        = is_pyld_col(r_la_col);
   assign w_p0_end         = (r_la_row == LAST_ROW) && (r_la_col == LAST_COL);
   assign w_rd_en          = w_p0_active && w_p0_pyld && !bus.i_fifo_empty && !i_rst;
   assign bus.o_fifo_rd_en = w_rd_en;
   assign w_p1_end         = r_p1_active && (r_p1_row == LAST_ROW) && (r_p1_col == LAST_COL);

   // Lookahead position advance and run/stop sequencing; a stop only takes effect at frame end.
   always_comb begin
      w_state_nxt  = r_state;
      w_la_row_nxt = r_la_row;
      w_la_col_nxt = r_la_col;
      if (w_p0_active) begin
         if (r_la_col == LAST_COL) begin
            w_la_col_nxt = 11'd0;
            if (r_la_row == LAST_ROW) begin
               w_la_row_nxt = 2'd0;
            end else begin
               w_la_row_nxt = r_la_row + 2'd1;
            end
         end else begin
            w_la_col_nxt = r_la_col + 11'd1;
         end
      end else begin
         w_la_row_nxt = 2'd0;
         w_la_col_nxt = 11'd0;
      end
      case (r_state)
         ST_IDLE: begin
            if (i_en) begin
               w_state_nxt = ST_RUN;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_RUN, ST_STOP: begin
            if (i_en) begin
               w_state_nxt = ST_RUN;
            end else if (w_p0_end) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_state_nxt = ST_STOP;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // State and lookahead position register.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state  <= ST_IDLE;
         r_la_row <= 2'd0;
         r_la_col <= 11'd0;
      end else begin
         r_state  <= w_state_nxt;
         r_la_row <= w_la_row_nxt;
         r_la_col <= w_la_col_nxt;
      end
   end

   // P1 and output stages; data, valid and position stay aligned to the FIFO read latency.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_p1_active           <= 1'b0;
         r_p1_row              <= 2'd0;
         r_p1_col              <= 11'd0;
         r_p1_pyld             <= 1'b0;
         r_p1_rd               <= 1'b0;
         r_p1_stuff            <= 1'b0;
         bus.o_row_cnt         <= 2'd0;
         bus.o_col_cnt         <= 11'd0;
         bus.o_pyld_data       <= 8'h00;
         bus.o_pyld_data_valid <= 1'b0;
         bus.o_stuff           <= 1'b0;
         bus.o_frame_start     <= 1'b0;
         bus.o_map_active      <= 1'b0;
         o_frame_cnt           <= 16'd0;
         o_underrun_cnt        <= 16'd0;
      end else begin
         r_p1_active           <= w_p0_active;
         r_p1_row              <= w_p0_active ? r_la_row : 2'd0;
         r_p1_col              <= w_p0_active ? r_la_col : 11'd0;
         r_p1_pyld             <= w_p0_active && w_p0_pyld;
         r_p1_rd               <= w_rd_en;
         r_p1_stuff            <= w_p0_active && w_p0_pyld && !w_rd_en;
         bus.o_row_cnt         <= r_p1_row;
         bus.o_col_cnt         <= r_p1_col;
         bus.o_pyld_data       <= r_p1_rd ? bus.i_fifo_data : (r_p1_stuff ? STUFF_BYTE : 8'h00);
         bus.o_pyld_data_valid <= r_p1_pyld;
         bus.o_stuff           <= r_p1_stuff;
         bus.o_frame_start     <= r_p1_active && (r_p1_row == 2'd0) && (r_p1_col == 11'd0);
         bus.o_map_active      <= r_p1_active;
         o_frame_cnt           <= w_p1_end ? (o_frame_cnt + 16'd1) : o_frame_cnt;
         o_underrun_cnt        <= (r_p1_stuff && (o_underrun_cnt != 16'hFFFF)) ?
                                  (o_underrun_cnt + 16'd1) : o_underrun_cnt;
      end
   end
endmodule
